pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined successor to the single-bit half adder: a WIDTH-bit adder with carry-in and carry-out whose carry chain is split into STAGES registered chunks. Operands enter through a valid/ready handshake, and results leave through a matching valid/ready handshake with backpressure. It is the datapath-grade adder for wide operands where the full carry chain does not close timing in one cycle.

## Interface
- WIDTH, 16: operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline stages; each stage adds a CW = WIDTH/STAGES bit chunk; 1 ≤ STAGES ≤ WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  adder accepts operands this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  present only with SUBTRACT_EN; 1 = compute x − y
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum
- c  output  1  carry-out (with sub = 1: 1 means no borrow)

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global advance enable: en = !out_valid || out_ready; in_ready = en (combinational, no dependence on in_valid).
- When en = 1, every stage register loads from its predecessor. Stage 0 loads from the inputs. Valid bits shift with the data, and bubbles (valid = 0) shift like data. Bubbles are not collapsed.
- When en = 0, all stage registers hold.
- Stage k (0-based) adds operand bits [k·CW +: CW] plus the carry registered by stage k−1 (cin for stage 0). It registers:
  - the CW-bit chunk sum,
  - the chunk carry,
  - the already-computed lower result bits,
  - the not-yet-used upper operand bits.
- Final stage output: s = the concatenated chunk sums; c = the carry of the top chunk.
- Arithmetic: {c, s} = x + y + cin, exact modulo 2^(WIDTH+1). No saturation and no overflow flag.
- Reset: all valid bits = 0, all data registers = 0, hence out_valid = 0, s = 0, c = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight transaction. No result for those transactions ever appears.
- Simultaneous output transfer and input transfer in one cycle is legal and sustains full throughput.
- Results are delivered strictly in input order.
- While out_valid = 1 and out_ready = 0, s and c hold stable.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid = 1 after edge N+STAGES−1 and is visible on the outputs from that cycle on. There is one register per stage, and the final stage register is the output.
- Throughput: one transaction per cycle while out_ready = 1.
- Backpressure: out_ready low freezes the whole pipeline in the same cycle, via in_ready falling combinationally.
- No combinational path from x, y, cin or sub to s or c. The only combinational path is out_ready → in_ready.

## Configuration
- SUBTRACT_EN defined:
  - port sub exists and is registered alongside the operands;
  - stage 0 uses y ^ {WIDTH{sub}} and carry-in cin ^ sub, so sub = 1, cin = 0 gives x − y;
  - sub = 1, cin = 1 gives x − y − 1.
- SUBTRACT_EN undefined: no sub port; addition only. Gate count and timing are identical to the pure adder.

## Test plan
- Reset then a single add: WIDTH = 16, STAGES = 4, x = 0xFFFF, y = 0x0001, cin = 0, out_ready = 1 → out_valid rises exactly 4 cycles after acceptance with s = 0x0000, c = 1. Then 0x1234 + 0x4321 with cin = 1 → s = 0x5556, c = 0.
- Streaming: 100 back-to-back random transactions with out_ready = 1 → one result per cycle, in order, each matching a {c, s} reference model. in_ready stays 1 throughout.
- Backpressure: stream with out_ready toggled pseudo-randomly at 50% → no result lost or duplicated; s and c stable while stalled; in_ready == !out_valid || out_ready every cycle.
- Reset mid-operation: accept 3 transactions, assert rst for 1 cycle → out_valid = 0, s = 0, c = 0 next cycle; none of the 3 results ever emerge.
- SUBTRACT_EN build: x = 0x0005, y = 0x0007, sub = 1, cin = 0 → s = 0xFFFE, c = 0. Then x = 0x0007, y = 0x0005 → s = 0x0002, c = 1.
- Parameter corners: STAGES = 1 (latency 1, single chunk) and STAGES = WIDTH = 8 (CW = 1, latency 8). Each with 0xFF + 0x01 → s = 0x00, c = 1.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with carry-in/carry-out. The carry chain
// is split into STAGES registered chunks of CW = WIDTH/STAGES bits each.
// Operands enter and results leave through valid/ready handshakes. Any
// output stall freezes the whole pipeline.
//
// Optional feature macro: SUBTRACT_EN. When defined, a `sub` port exists.
// With sub = 1, stage 0 inverts y and the carry-in, so the result is x - y - cin.
//
// Stage k register contents:
//   a_q  - lower (k+1)*CW result bits, with the still-unused upper x bits above them
//   b_q  - the still-unused upper y bits (omitted in the final stage)
//   c_q  - carry out of chunk k
//   v_q  - valid bit, which travels with the data (bubbles included)
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int CW = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] y_eff;
    logic             cin_eff;

    // The pipeline advances whenever the output register is empty or being drained.
    // out_ready -> in_ready is the only combinational path through the block.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

`ifdef SUBTRACT_EN
    // Two's-complement subtraction: invert y and the carry-in at the pipeline entry.
    assign y_eff   = y ^ {WIDTH{sub}};
    assign cin_eff = cin ^ sub;
`else
    assign y_eff   = y;
    assign cin_eff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;        // first operand bit added in this stage
        localparam int HI = (k + 1) * CW;  // bits consumed once this stage is done

        logic [WIDTH-1:0]    a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in;
        logic                v_in;
        logic [CW-1:0]       chunk_sum;
        logic                chunk_carry;
        logic [WIDTH-1:0]    a_nxt;
        logic [WIDTH-1:0]    a_q;
        logic                c_q;
        logic                v_q;

        if (k == 0) begin : g_src
            assign a_in = x;
            assign b_in = y_eff;
            assign c_in = cin_eff;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].g_ops.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        // Chunk add for this stage: CW operand bits plus the carry from the previous stage.
        assign {chunk_carry, chunk_sum} = {1'b0, a_in[LO +: CW]}
                                        + {1'b0, b_in[CW-1:0]}
                                        + {{CW{1'b0}}, c_in};

        // Merge the new chunk sum into the word that carries the finished bits and the pending x bits.
        always_comb begin
            // NOTE: assign a full default first so no path leaves a_nxt unassigned, which would infer a latch.
            a_nxt           = a_in;
            a_nxt[LO +: CW] = chunk_sum;
        end

        // Stage register: loads on advance, holds on stall, and clears on reset.
        always_ff @(posedge clk) begin
            // NOTE: state updates are non-blocking, so every stage samples its predecessor's old value on the same edge.
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= chunk_carry;
                a_q <= a_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-HI-1:0] b_q;

            // Forward the y bits that later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_q <= '0;
                end else if (en) begin
                    b_q <= b_in[WIDTH-LO-1:CW];
                end
            end
        end
    end

    // The final stage register is the output.
    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].a_q;
    assign c         = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder. The main DUT uses WIDTH = 16, STAGES = 4.
// Two 8-bit corner instances are included: STAGES = 1 and STAGES = 8.
// A queue-based arithmetic reference model is checked on every negedge.
// Directed results use hand-computed literal expectations.
module tb_pipelined_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         c;

    // corner instances share one stimulus
    logic       k_valid = 1'b0;
    logic [7:0] k_x = '0;
    logic [7:0] k_y = '0;
    logic       k1_ready, k1_valid, k1_c;
    logic       k8_ready, k8_valid, k8_c;
    logic [7:0] k1_s, k8_s;

    int errors = 0;
    int checks = 0;
    bit bp_mode = 1'b0;

    logic [W:0] exp_q[$];
    bit         stalled = 1'b0;
    logic [W:0] held = '0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(k_valid), .in_ready(k1_ready),
        .x(k_x), .y(k_y), .cin(1'b0),
`ifdef SUBTRACT_EN
        .sub(1'b0),
`endif
        .out_valid(k1_valid), .out_ready(1'b1), .s(k1_s), .c(k1_c)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(k_valid), .in_ready(k8_ready),
        .x(k_x), .y(k_y), .cin(1'b0),
`ifdef SUBTRACT_EN
        .sub(1'b0),
`endif
        .out_valid(k8_valid), .out_ready(1'b1), .s(k8_s), .c(k8_c)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic: add gives x+y+cin; subtract gives 2^W + x - y - cin, both mod 2^(W+1).
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
        longint r;
        if (sb) r = (longint'(1) << W) + longint'(a) - longint'(b) - longint'(ci);
        else    r = longint'(a) + longint'(b) + longint'(ci);
        return r[W:0];
    endfunction

    // Compare process: handshake rule, stall stability, and in-order results against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (stalled) check("stall_hold", {15'b0, c, s}, {15'b0, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_result: got %h with no pending transaction", {c, s});
                end else begin
                    check("result", {15'b0, c, s}, {15'b0, exp_q.pop_front()});
                end
            end
            stalled = out_valid && !out_ready;
            held    = {c, s};
`ifdef SUBTRACT_EN
            if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
`else
            if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, 1'b0));
`endif
        end
    end

    // Pseudo-random backpressure while enabled.
    always @(posedge clk) begin
        if (bp_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one transaction and hold it until accepted; returns the number of stalled cycles.
    task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic cv,
                        input logic sv, output int waits);
        bit done;
        x = xv; y = yv; cin = cv; sub = sv; in_valid = 1'b1;
        waits = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            if (!done) begin
                waits++;
                if (waits > 200) begin
                    errors++; checks++;
                    $display("FAIL send_timeout: waited %0d cycles, required acceptance", waits);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid is seen; returns 0 if it never appears.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin n = i; break; end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    logic [W-1:0] vx[8] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h00FF, 16'h0FFF, 16'hAAAA, 16'h7FFF, 16'hF0F0};
    logic [W-1:0] vy[8] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h0001, 16'h5555, 16'h0001, 16'h0F10};
    logic         vc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int w;
        int seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_s", {16'b0, s}, 0);
        check("reset_c", {31'b0, c}, 0);
        check("reset_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // Single add: latency 4 and literal result.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        wait_valid(n);
        check("latency_stages4", n, 4);
        check("ffff_plus_1_s", {16'b0, s}, 32'h0000);
        check("ffff_plus_1_c", {31'b0, c}, 1);
        @(posedge clk); #1;
        send(16'h1234, 16'h4321, 1'b1, 1'b0, w);
        wait_valid(n);
        check("add_cin_s", {16'b0, s}, 32'h5556);
        check("add_cin_c", {31'b0, c}, 0);
        @(posedge clk); #1;

        // Directed carry-boundary vectors, back to back.
        for (int i = 0; i < 8; i++) send(vx[i], vy[i], vc[i], 1'b0, w);
        drain();

        // Streaming: 100 back-to-back transactions and no stalls.
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, w);
            check("stream_no_stall", w, 0);
        end
        drain();

        // Backpressure: random out_ready.
        bp_mode = 1'b1;
        for (int i = 0; i < 60; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, w);
        bp_mode = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Reset mid-operation: three in flight, then discarded.
        for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_s", {16'b0, s}, 0);
        check("midrst_c", {31'b0, c}, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_results", seen, 0);
        @(posedge clk); #1;

`ifdef SUBTRACT_EN
        // Subtraction: 5 - 7 borrows, 7 - 5 does not.
        send(16'h0005, 16'h0007, 1'b0, 1'b1, w);
        wait_valid(n);
        check("sub_5_7_s", {16'b0, s}, 32'hFFFE);
        check("sub_5_7_c", {31'b0, c}, 0);
        @(posedge clk); #1;
        send(16'h0007, 16'h0005, 1'b0, 1'b1, w);
        wait_valid(n);
        check("sub_7_5_s", {16'b0, s}, 32'h0002);
        check("sub_7_5_c", {31'b0, c}, 1);
        @(posedge clk); #1;
        send(16'h0007, 16'h0005, 1'b1, 1'b1, w);
        wait_valid(n);
        check("sub_7_5_cin_s", {16'b0, s}, 32'h0001);
        sub = 1'b0;
        drain();
`endif

        // Parameter corners: STAGES = 1 (latency 1) and STAGES = 8 (latency 8).
        k_x = 8'hFF; k_y = 8'h01; k_valid = 1'b1;
        @(negedge clk);
        check("corner_ready", {30'b0, k1_ready, k8_ready}, 32'h3);
        @(posedge clk); #1 k_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("c1_valid", {31'b0, k1_valid}, {31'b0, (i == 1)});
            check("c8_valid", {31'b0, k8_valid}, {31'b0, (i == 8)});
            if (i == 1) check("c1_sum", {23'b0, k1_c, k1_s}, 32'h100);
            if (i == 8) check("c8_sum", {23'b0, k8_c, k8_s}, 32'h100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
